// File: rtl/seq_mac.sv
// Sequential multiply-accumulate: one shift-add step per cycle over W cycles,
// then sign fix-up and accumulate. Valid/ready handshakes on both sides.
module seq_mac #(
   parameter int W = 12,
   parameter int G = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         a,
   input  logic [W-1:0]         b,
   input  logic                 is_signed,
   input  logic                 accumulate,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*W+G-1:0]     result,
   output logic                 overflow
);

   localparam int ACC_W = 2*W + G;
   localparam int CW    = $clog2(W) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state;
   logic [W-1:0]       ma;
   logic [W-1:0]       mb;
   logic               neg;
   logic               sgn;
   logic               acc_mode;
   logic [CW-1:0]      cnt;
   logic [2*W-1:0]     prod;
   logic [ACC_W-1:0]   acc;

   logic [W-1:0]       a_mag;
   logic [W-1:0]       b_mag;
   logic [W:0]         step_sum;
   logic [2*W-1:0]     prod_next;
   logic [2*W-1:0]     prod_s;
   logic [ACC_W-1:0]   ext;
   logic [ACC_W:0]     sum;
   logic               ovf_next;

   // Operand magnitudes, one shift-add step, and the FIN-stage sign fix-up/add
   always_comb begin
      a_mag = (is_signed && a[W-1]) ? (~a + W'(1)) : a;
      b_mag = (is_signed && b[W-1]) ? (~b + W'(1)) : b;

      // add multiplicand into the upper half (carry kept), then shift right
      step_sum  = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? ma : '0)};
      prod_next = {step_sum, prod[W-1:1]};

      prod_s = neg ? (~prod + (2*W)'(1)) : prod;
      ext    = sgn ? {{G{prod_s[2*W-1]}}, prod_s} : {{G{1'b0}}, prod_s};
      sum    = acc_mode ? ({1'b0, acc} + {1'b0, ext}) : {1'b0, ext};

      ovf_next = 1'b0;
      if (acc_mode) begin
         if (sgn)
            ovf_next = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
         else
            ovf_next = sum[ACC_W];
      end
   end

   // Control FSM with registered handshake outputs and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ma        <= '0;
         mb        <= '0;
         neg       <= 1'b0;
         sgn       <= 1'b0;
         acc_mode  <= 1'b0;
         cnt       <= '0;
         prod      <= '0;
         acc       <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ma       <= a_mag;
                  mb       <= b_mag;
                  neg      <= is_signed & (a[W-1] ^ b[W-1]);
                  sgn      <= is_signed;
                  acc_mode <= accumulate;
                  cnt      <= '0;
                  prod     <= {{W{1'b0}}, b_mag};
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               prod <= prod_next;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(W-1))
                  state <= FIN;
            end
            FIN: begin
               acc       <= sum[ACC_W-1:0];
               overflow  <= ovf_next;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign result = acc;

endmodule

// File: tb/tb_seq_mac.sv
// Directed bench for seq_mac (W=12, G=4, ACC_W=28) with hand-computed expectations.
module tb_seq_mac;

   localparam int W = 12;
   localparam int G = 4;
   localparam int ACC_W = 2*W + G;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      a = '0;
   logic [W-1:0]      b = '0;
   logic              is_signed = 1'b0;
   logic              accumulate = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ACC_W-1:0]  result;
   logic              overflow;

   int checks = 0;
   int errors = 0;
   int lat;

   seq_mac #(.W(W), .G(G)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .is_signed  (is_signed),
      .accumulate (accumulate),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one operand pair and wait (bounded) for out_valid; out_ready stays low.
   // Latency counts the accepting edge as edge 1.
   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic sg,
                      input logic ac, output int n);
      @(negedge clk);
      a = ta; b = tb_; is_signed = sg; accumulate = ac; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = '1; b = '1;
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Consume the result and confirm the return to IDLE
   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic seen;
      logic [ACC_W-1:0] held;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_ir", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // unsigned 4095*4095, replace
      @(negedge clk);
      a = 12'hFFF; b = 12'hFFF; is_signed = 1'b0; accumulate = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("calc_ir_low", 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("u_max_lat", 32'(lat), 32'd14);
      chk("u_max_res", 32'(result), 32'h0FFE001);
      chk("u_max_ovf", 32'(overflow), 32'd0);

      // hold in DONE with out_ready low; new offers must be ignored
      held = result;
      in_valid = 1'b1; a = 12'd1; b = 12'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_res", 32'(result), 32'(held));
         chk("hold_ov", 32'(out_valid), 32'd1);
         chk("hold_ir", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_out("u_max");

      // signed -2048 * -2048
      run(12'h800, 12'h800, 1'b1, 1'b0, lat);
      chk("s_min_lat", 32'(lat), 32'd14);
      chk("s_min_res", 32'(result), 32'h0400000);
      chk("s_min_ovf", 32'(overflow), 32'd0);
      release_out("s_min");

      // signed -3 * 5
      run(12'hFFD, 12'd5, 1'b1, 1'b0, lat);
      chk("s_neg_res", 32'(result), 32'hFFFFFF1);
      chk("s_neg_ovf", 32'(overflow), 32'd0);
      release_out("s_neg");

      // unsigned 100*200 then accumulate 300*400
      run(12'd100, 12'd200, 1'b0, 1'b0, lat);
      chk("u_a_res", 32'(result), 32'd20000);
      chk("u_a_ovf", 32'(overflow), 32'd0);
      release_out("u_a");
      run(12'd300, 12'd400, 1'b0, 1'b1, lat);
      chk("u_b_res", 32'(result), 32'd140000);
      chk("u_b_ovf", 32'(overflow), 32'd0);
      release_out("u_b");

      // signed accumulate of -15 onto 140000
      run(12'hFFD, 12'd5, 1'b1, 1'b1, lat);
      chk("s_acc_res", 32'(result), 32'd139985);
      chk("s_acc_ovf", 32'(overflow), 32'd0);
      release_out("s_acc");

      // reset during the 6th CALC cycle
      @(negedge clk);
      a = 12'd50; b = 12'd60; is_signed = 1'b0; accumulate = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_res", 32'(result), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      chk("mid_rst_ir", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      chk("mid_rst_no_pulse", 32'(seen), 32'd0);
      run(12'd7, 12'd9, 1'b0, 1'b1, lat);
      chk("post_rst_res", 32'(result), 32'd63);
      release_out("post_rst");

      // 17 unsigned max products accumulated from zero; wraps on the 17th
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         run(12'hFFF, 12'hFFF, 1'b0, 1'b1, lat);
         chk("wrap_ovf", 32'(overflow), (k == 17) ? 32'd1 : 32'd0);
         if (k == 16) chk("wrap_res16", 32'(result), 32'd268304400);
         release_out("wrap");
      end
      chk("wrap_res17", 32'(result), 32'd16637969);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
